disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan scheduler for the four-digit multiplexed seven-segment display. Holds a double-buffered per-digit register file written by the host and cycles digit enables with a programmable dwell time and anti-ghosting blanking gap. Decodes hex to segments and commits host updates only at frame boundaries, so the display never tears. Sits between host control logic and the Seg/Sl pads.

## Interface
- CLK_DIV, 1000: Clk cycles a digit stays lit (SHOW dwell), ≥1
- BLANK_CYC, 8: Clk cycles all digits off between digits (BLANK gap), ≥1
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Enable  in  1  scanning on when high; display dark when low
- Wr_en  in  1  write strobe into the shadow register file
- Wr_addr  in  2  shadow digit index 0..3
- Wr_data  in  4  hex value for the digit
- Wr_dp  in  1  decimal point for the digit
- Wr_blank  in  1  digit forced dark when 1
- Commit_req  in  1  level request to copy shadow → active
- Commit_ack  out  1  one-cycle pulse when the copy occurs
- Frame_start  out  1  one-cycle pulse at the start of digit 0's BLANK
- Seg  out  8  segments, bit0=a … bit6=g, bit7=dp; 1 = lit
- Sl  out  4  digit enables, active-low; Sl[i] low selects digit i

## Operation
- Register files: shadow[4] and active[4], each {blank, dp, data[3:0]}. Reset value is 0 in every entry.
- Wr_en writes shadow[Wr_addr] on the clock edge. Active is written only by a commit.
- FSM states are IDLE, BLANK and SHOW. The block also holds a 2-bit digit index and a cycle counter.
  - IDLE: entered at reset. Moves to BLANK (digit=0) when Enable=1.
  - BLANK: runs BLANK_CYC cycles, then moves to SHOW.
  - SHOW: runs CLK_DIV cycles, then moves to BLANK. The digit index increments and wraps 3→0.
- Enable=0 in any state → IDLE on the next edge, with digit reset to 0 and counter reset to 0.
- Frame end is the last SHOW cycle of digit 3. In IDLE, every cycle counts as a frame end.
- Commit: if Commit_req=1 at a frame end, all four active entries are copied from shadow on that edge and Commit_ack pulses during the following cycle. The requester holds Commit_req until it sees the ack. If Commit_req is still high in the cycle after the ack, that counts as a new request.
- Wr_en on the same edge as a commit: the copy takes the pre-write shadow contents, and the write lands in shadow only.
- Segment decode (g..a, hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Seg[7]=dp.
- In SHOW: Sl = ~(1<<digit). Seg = decode(active[digit]), or 8'h00 if that entry's blank bit is set.
- In BLANK and IDLE: Sl=4'b1111, Seg=8'h00.

## Timing
- Sl, Seg, Commit_ack and Frame_start are registered outputs. They are driven from the next-state logic, so they change on the same edge the FSM changes state.
- Reset values: Sl=4'b1111, Seg=8'h00, Commit_ack=0, Frame_start=0, state IDLE, digit 0. These hold while Reset=0.
- Reset asserted mid-scan: outputs go to reset values immediately, with no clock required. A pending commit is dropped.
- Scan start: Enable is sampled high at edge E. From edge E the state is BLANK for digit 0 and Frame_start is high for one cycle. Sl[0] goes low at edge E+BLANK_CYC.
- Frame length is 4·(BLANK_CYC+CLK_DIV) cycles. Frame_start pulses once per frame.
- No two Sl bits are ever low together. At least BLANK_CYC cycles with Sl=1111 separate consecutive digits.
- Commit latency: 1 cycle after request in IDLE. During scanning, at most one frame.

## Test plan
- CLK_DIV=4, BLANK_CYC=2. Reset low → Sl=1111, Seg=00, both pulse outputs 0. Release Reset with Enable=0 → outputs unchanged.
- Write shadow 0..3 = 1,2,3,4 (dp on digit 2), Commit_req with Enable=0 → Commit_ack after 1 cycle. Enable=1 → sequence of 2 cycles dark, then Sl=1110/Seg=06 for 4 cycles, 2 dark, 1101/5B, 2 dark, 1011/CF, 2 dark, 0111/66, repeating every 24 cycles. Frame_start pulses every 24 cycles.
- While scanning, write shadow[0]=F and assert Commit_req mid-frame → digit 0 keeps showing 06 until the frame end. The ack comes on the edge after digit 3's last SHOW cycle, and the next frame shows 71.
- Wr_en to the shadow entry on the commit edge → active receives the old value and shadow the new one. A second commit then applies the new value.
- Wr_blank=1 on digit 1 plus commit → Seg=00 while Sl=1101. The Sl timing is unchanged.
- Drop Enable during SHOW of digit 2 → the next edge gives Sl=1111/Seg=00. Re-enabling restarts at digit 0 with Frame_start. Pulse Reset low mid-SHOW → outputs clear asynchronously.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Host-side bundle for the seven-segment scan controller.
// commit_req is a level held by the host until it sees the one-cycle commit_ack.
// A request still high in the cycle after the ack is treated as a new request.
interface disp_scan_ctrl_if;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_blank;
    logic       commit_req;
    logic       commit_ack;
    logic       frame_start;
    logic [7:0] seg;
    logic [3:0] sl;
    logic [1:0] state_dbg;
    logic [1:0] digit_dbg;

    modport master (
        output enable, wr_en, wr_addr, wr_data, wr_dp, wr_blank, commit_req,
        input  commit_ack, frame_start, seg, sl, state_dbg, digit_dbg
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data, wr_dp, wr_blank, commit_req,
        output commit_ack, frame_start, seg, sl, state_dbg, digit_dbg
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a double-buffered digit file
// that is committed only at frame boundaries, and blanking gaps between digits.
module disp_scan_ctrl #(
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    disp_scan_ctrl_if.slave bus
);

    localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] data;
    } digit_t;

    digit_t shadow [4];
    digit_t active [4];

    state_t        state;
    logic [1:0]    digit;
    logic [CW-1:0] cnt;
    logic [3:0]    sl_q;
    logic [7:0]    seg_q;
    logic          ack_q;
    logic          fs_q;

    state_t        nxt_state;
    logic [1:0]    nxt_digit;
    logic [CW-1:0] nxt_cnt;
    logic          frame_end;
    logic          do_commit;
    logic          frame_open;
    digit_t        nxt_ent;
    logic [7:0]    nxt_seg;
    logic [3:0]    nxt_sl;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_digit = digit;
        nxt_cnt   = cnt;
        if (!bus.enable) begin
            nxt_state = ST_IDLE;
            nxt_digit = 2'd0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    nxt_state = ST_BLANK;
                    nxt_digit = 2'd0;
                    nxt_cnt   = '0;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = ST_SHOW;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        nxt_state = ST_BLANK;
                        nxt_digit = digit + 2'd1;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_digit = 2'd0;
                    nxt_cnt   = '0;
                end
            endcase
        end

        // Idle counts as a permanent frame boundary; the ack cycle's request is the one just served.
        frame_end  = (state == ST_IDLE) ||
                     ((state == ST_SHOW) && (digit == 2'd3) && (cnt == SHOW_LAST));
        do_commit  = bus.commit_req && !ack_q && frame_end;
        frame_open = (nxt_state == ST_BLANK) && (state != ST_BLANK) && (nxt_digit == 2'd0);

        // A commit never coincides with entering SHOW, so active is stable here.
        nxt_ent = active[nxt_digit];
        nxt_seg = 8'h00;
        nxt_sl  = 4'b1111;
        if (nxt_state == ST_SHOW) begin
            nxt_sl = ~(4'b0001 << nxt_digit);
            if (!nxt_ent.blank) begin
                nxt_seg = {nxt_ent.dp, hex7(nxt_ent.data)};
            end
        end
    end

    // Nonblocking copy: a write on the commit edge lands only in shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (do_commit) begin
                for (int i = 0; i < 4; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (bus.wr_en) begin
                shadow[bus.wr_addr] <= '{blank: bus.wr_blank, dp: bus.wr_dp, data: bus.wr_data};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            digit <= 2'd0;
            cnt   <= '0;
            sl_q  <= 4'b1111;
            seg_q <= 8'h00;
            ack_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            state <= nxt_state;
            digit <= nxt_digit;
            cnt   <= nxt_cnt;
            sl_q  <= nxt_sl;
            seg_q <= nxt_seg;
            ack_q <= do_commit;
            fs_q  <= frame_open;
        end
    end

    assign bus.sl          = sl_q;
    assign bus.seg         = seg_q;
    assign bus.commit_ack  = ack_q;
    assign bus.frame_start = fs_q;
    assign bus.state_dbg   = state;
    assign bus.digit_dbg   = digit;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: per-frame phase table plus hand-written
// sequences for commits, blanking, enable drop and asynchronous reset.
module tb_disp_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    disp_scan_ctrl_if bus();

    disp_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame as eight phases: dark gap, then a lit digit (dig<0 means dark).
    typedef struct {
        int         cycles;
        logic [3:0] sl;
        int         dig;
    } phase_t;

    phase_t ph [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_digit(input logic [1:0] addr, input logic [3:0] data,
                               input logic dp, input logic blank);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        bus.wr_dp    = dp;
        bus.wr_blank = blank;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (!bus.commit_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.commit_ack, 1'b1);
        bus.commit_req = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3,
                               input logic ack0);
        logic [7:0] segs [4];
        logic [7:0] exp_seg;
        int cyc;
        segs = '{s0, s1, s2, s3};
        cyc = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < ph[p].cycles; c++) begin
                @(negedge clk);
                exp_seg = (ph[p].dig < 0) ? 8'h00 : segs[ph[p].dig];
                check("frame_sl", bus.sl, ph[p].sl);
                check("frame_seg", bus.seg, exp_seg);
                check("frame_start", bus.frame_start, cyc == 0);
                check("frame_ack", bus.commit_ack, (cyc == 0) && ack0);
                cyc++;
            end
        end
    endtask

    initial begin
        int lat;
        ph[0] = '{BLANK_CYC, 4'b1111, -1};
        ph[1] = '{CLK_DIV,   4'b1110,  0};
        ph[2] = '{BLANK_CYC, 4'b1111, -1};
        ph[3] = '{CLK_DIV,   4'b1101,  1};
        ph[4] = '{BLANK_CYC, 4'b1111, -1};
        ph[5] = '{CLK_DIV,   4'b1011,  2};
        ph[6] = '{BLANK_CYC, 4'b1111, -1};
        ph[7] = '{CLK_DIV,   4'b0111,  3};

        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 2'd0;
        bus.wr_data    = 4'd0;
        bus.wr_dp      = 1'b0;
        bus.wr_blank   = 1'b0;
        bus.commit_req = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sl", bus.sl, 4'b1111);
        check("rst_seg", bus.seg, 8'h00);
        check("rst_ack", bus.commit_ack, 1'b0);
        check("rst_fs", bus.frame_start, 1'b0);
        check("rst_state", bus.state_dbg, 2'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sl", bus.sl, 4'b1111);
        check("idle_seg", bus.seg, 8'h00);
        check("idle_fs", bus.frame_start, 1'b0);
        check("idle_ack", bus.commit_ack, 1'b0);

        write_digit(2'd0, 4'h1, 1'b0, 1'b0);
        write_digit(2'd1, 4'h2, 1'b0, 1'b0);
        write_digit(2'd2, 4'h3, 1'b1, 1'b0);
        write_digit(2'd3, 4'h4, 1'b0, 1'b0);

        // Commit while idle: acknowledged one cycle after the request.
        bus.commit_req = 1'b1;
        lat = 0;
        while (!bus.commit_ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bus.commit_req = 1'b0;
        check("idle_commit_lat", lat, 1);
        @(negedge clk);
        check("idle_ack_one_cycle", bus.commit_ack, 1'b0);

        bus.enable = 1'b1;
        check_frame(8'h06, 8'h5B, 8'hCF, 8'h66, 1'b0);
        check_frame(8'h06, 8'h5B, 8'hCF, 8'h66, 1'b0);

        // Mid-frame update of digit 0 waits for the frame end.
        fork
            begin
                check_frame(8'h06, 8'h5B, 8'hCF, 8'h66, 1'b0);
                check_frame(8'h71, 8'h5B, 8'hCF, 8'h66, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                write_digit(2'd0, 4'hF, 1'b0, 1'b0);
                bus.commit_req = 1'b1;
                wait_ack("scan_commit_ack");
            end
        join

        // Write on the commit edge, then a blank digit 1 with the follow-up commit.
        fork
            begin
                check_frame(8'h71, 8'h5B, 8'hCF, 8'h66, 1'b0);
                check_frame(8'h71, 8'h5B, 8'hCF, 8'h07, 1'b1);
                check_frame(8'h71, 8'h00, 8'hCF, 8'h7F, 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                write_digit(2'd3, 4'h7, 1'b0, 1'b0);
                bus.commit_req = 1'b1;
                repeat (20) @(negedge clk);
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 2'd3;
                bus.wr_data  = 4'h8;
                bus.wr_dp    = 1'b0;
                bus.wr_blank = 1'b0;
                @(negedge clk);
                bus.wr_en = 1'b0;
                check("edge_write_ack", bus.commit_ack, 1'b1);
                bus.commit_req = 1'b0;
                @(negedge clk);
                write_digit(2'd1, 4'h2, 1'b0, 1'b1);
                bus.commit_req = 1'b1;
                wait_ack("blank_commit_ack");
            end
        join

        // Drop enable while digit 2 is lit.
        repeat (16) @(negedge clk);
        check("pre_drop_sl", bus.sl, 4'b1011);
        check("pre_drop_seg", bus.seg, 8'hCF);
        bus.enable = 1'b0;
        @(negedge clk);
        check("drop_sl", bus.sl, 4'b1111);
        check("drop_seg", bus.seg, 8'h00);
        check("drop_state", bus.state_dbg, 2'd0);
        check("drop_digit", bus.digit_dbg, 2'd0);
        repeat (3) @(negedge clk);
        check("disabled_sl", bus.sl, 4'b1111);
        check("disabled_fs", bus.frame_start, 1'b0);

        bus.enable = 1'b1;
        check_frame(8'h71, 8'h00, 8'hCF, 8'h7F, 1'b0);

        // Asynchronous reset in the middle of digit 0's SHOW.
        repeat (3) @(negedge clk);
        check("pre_rst_sl", bus.sl, 4'b1110);
        check("pre_rst_seg", bus.seg, 8'h71);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sl", bus.sl, 4'b1111);
        check("async_rst_seg", bus.seg, 8'h00);
        check("async_rst_state", bus.state_dbg, 2'd0);
        @(negedge clk);
        check("held_rst_sl", bus.sl, 4'b1111);
        check("held_rst_fs", bus.frame_start, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
